// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Requests are in-order; responses return in request order.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order imem requests,
// buffers returned words in a small FIFO and drives the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          BranchTakenE,
  input  logic [31:0]   BranchTargetE,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCPlus8D,
  output logic          ValidD
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_stage: DEPTH must be a power of 2 and at least 2");
  end

  // Fetch-side state
  logic [31:0]      pc_f, pc_f_n;
  logic [31:0]      resp_pc, resp_pc_n;
  logic [CNT_W-1:0] outstanding, outstanding_n;
  logic [CNT_W-1:0] stale, stale_n;

  // In-order word buffer
  logic [31:0]      fifo_instr [DEPTH];
  logic [31:0]      fifo_pc    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_n;

  // IF/ID next values
  logic [31:0]      instr_d_n;
  logic [31:0]      pc8_d_n;
  logic             valid_d_n;

  logic [SUM_W-1:0] inflight;
  logic             req;
  logic             grant;
  logic             resp;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // Credits cover both in-flight requests and buffered words, so the FIFO cannot overflow.
  assign inflight   = SUM_W'(outstanding) + SUM_W'(fifo_cnt);
  assign req        = !reset && (inflight < SUM_W'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_f;

  assign grant = req && imem.imem_gnt;
  // A response with nothing in flight is a protocol error and is dropped.
  assign resp  = imem.imem_rvalid && (outstanding != '0);
  // Responses owed to requests issued before a redirect are never buffered.
  assign push  = !reset && resp && (stale == '0) && !BranchTakenE;
  assign pop   = !BranchTakenE && !StallD && !fifo_empty;

  // Next-state for PC, request bookkeeping and FIFO pointers
  always_comb begin
    pc_f_n        = pc_f;
    resp_pc_n     = resp_pc;
    outstanding_n = outstanding + CNT_W'(grant) - CNT_W'(resp);
    stale_n       = stale;
    wr_ptr_n      = wr_ptr;
    rd_ptr_n      = rd_ptr;
    fifo_cnt_n    = fifo_cnt;

    if (BranchTakenE) begin
      pc_f_n     = BranchTargetE;
      resp_pc_n  = BranchTargetE;
      stale_n    = outstanding_n;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      fifo_cnt_n = '0;
    end else begin
      if (grant) begin
        pc_f_n = pc_f + 32'd4;
      end
      if (resp && (stale != '0)) begin
        stale_n = stale - CNT_W'(1);
      end
      if (push) begin
        resp_pc_n = resp_pc + 32'd4;
        wr_ptr_n  = wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_n = rd_ptr + PTR_W'(1);
      end
      fifo_cnt_n = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Next-state for the IF/ID register; redirect and flush both force a bubble.
  always_comb begin
    instr_d_n = InstrD;
    pc8_d_n   = PCPlus8D;
    valid_d_n = ValidD;

    if (BranchTakenE || FlushD) begin
      instr_d_n = 32'h0;
      valid_d_n = 1'b0;
    end else if (!StallD) begin
      if (!fifo_empty) begin
        instr_d_n = fifo_instr[rd_ptr];
        pc8_d_n   = fifo_pc[rd_ptr] + 32'd8;
        valid_d_n = 1'b1;
      end else begin
        instr_d_n = 32'h0;
        valid_d_n = 1'b0;
      end
    end
  end

  // Control state and IF/ID register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      InstrD      <= 32'h0;
      PCPlus8D    <= RESET_PC + 32'd8;
      ValidD      <= 1'b0;
    end else begin
      pc_f        <= pc_f_n;
      resp_pc     <= resp_pc_n;
      outstanding <= outstanding_n;
      stale       <= stale_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      fifo_cnt    <= fifo_cnt_n;
      InstrD      <= instr_d_n;
      PCPlus8D    <= pc8_d_n;
      ValidD      <= valid_d_n;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem.imem_rdata;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 1-cycle-latency imem model with grant/response
// gating, stepped cycle by cycle from a single initial block.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        StallD;
  logic        FlushD;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCPlus8D;
  logic        ValidD;

  fetch_stage_if mem ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .imem          (mem),
    .InstrD        (InstrD),
    .PCPlus8D      (PCPlus8D),
    .ValidD        (ValidD)
  );

  int          total = 0;
  int          bad   = 0;
  logic        gnt_en;
  logic        resp_en;
  logic        extra_rv;
  logic [31:0] q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hE000_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Memory model outputs: an injected garbage response overrides the queue head.
  task automatic drive_mem();
    mem.imem_gnt = gnt_en;
    if (extra_rv) begin
      mem.imem_rvalid = 1'b1;
      mem.imem_rdata  = 32'hDEAD_BEEF;
    end else if (resp_en && (q.size() > 0)) begin
      mem.imem_rvalid = 1'b1;
      mem.imem_rdata  = instr_of(q[0]);
    end else begin
      mem.imem_rvalid = 1'b0;
      mem.imem_rdata  = 32'h0;
    end
  endtask

  // One clock: sample the bus at negedge, update the model just after posedge.
  task automatic step();
    logic        g;
    logic [31:0] ga;
    logic        rvq;
    @(negedge clk);
    g   = mem.imem_req && mem.imem_gnt;
    ga  = mem.imem_addr;
    rvq = mem.imem_rvalid && !extra_rv;
    @(posedge clk);
    #1;
    if (rvq) q.delete(0);
    if (g) q.push_back(ga);
    drive_mem();
  endtask

  initial begin
    reset = 1'b1; StallD = 1'b0; FlushD = 1'b0;
    BranchTakenE = 1'b0; BranchTargetE = 32'h0;
    gnt_en = 1'b1; resp_en = 1'b1; extra_rv = 1'b0;
    drive_mem();
    step(); step();
    chk("rst_valid", 32'(ValidD), 32'd0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_pc8", PCPlus8D, 32'd8);
    chk("rst_req", 32'(mem.imem_req), 32'd0);
    chk("rst_addr", mem.imem_addr, 32'h0);

    // Zero-wait memory
    reset = 1'b0; #1;
    chk("s1_req", 32'(mem.imem_req), 32'd1);
    chk("s1_addr0", mem.imem_addr, 32'h0);
    step(); chk("s1_c1_valid", 32'(ValidD), 32'd0); chk("s1_c1_addr", mem.imem_addr, 32'h4);
    step(); chk("s1_c2_valid", 32'(ValidD), 32'd0); chk("s1_c2_req", 32'(mem.imem_req), 32'd0);
    step(); chk("s1_c3_valid", 32'(ValidD), 32'd1); chk("s1_c3_pc8", PCPlus8D, 32'd8);
            chk("s1_c3_instr", InstrD, instr_of(32'h0));
    step(); chk("s1_c4_pc8", PCPlus8D, 32'd12); chk("s1_c4_instr", InstrD, instr_of(32'h4));
    step(); chk("s1_c5_valid", 32'(ValidD), 32'd0);
    step(); chk("s1_c6_valid", 32'(ValidD), 32'd1); chk("s1_c6_pc8", PCPlus8D, 32'd16);

    // Decode stall for three cycles
    StallD = 1'b1;
    step(); chk("s2_h1_pc8", PCPlus8D, 32'd16); chk("s2_h1_instr", InstrD, instr_of(32'h8));
            chk("s2_h1_req", 32'(mem.imem_req), 32'd0);
    step(); chk("s2_h2_pc8", PCPlus8D, 32'd16); chk("s2_h2_req", 32'(mem.imem_req), 32'd0);
    step(); chk("s2_h3_pc8", PCPlus8D, 32'd16); chk("s2_h3_addr", mem.imem_addr, 32'd20);
    StallD = 1'b0;
    step(); chk("s2_r1_pc8", PCPlus8D, 32'd20); chk("s2_r1_instr", InstrD, instr_of(32'd12));
    step(); chk("s2_r2_pc8", PCPlus8D, 32'd24); chk("s2_r2_instr", InstrD, instr_of(32'd16));
    step(); chk("s2_r3_valid", 32'(ValidD), 32'd0);
    step(); chk("s2_r4_pc8", PCPlus8D, 32'd28); chk("s2_r4_valid", 32'(ValidD), 32'd1);

    // Redirect with two requests in flight
    resp_en = 1'b0; drive_mem();
    step(); chk("s3_a_pc8", PCPlus8D, 32'd32);
    step(); chk("s3_b_req", 32'(mem.imem_req), 32'd0); chk("s3_b_valid", 32'(ValidD), 32'd0);
    BranchTakenE = 1'b1; BranchTargetE = 32'h100;
    step();
    BranchTakenE = 1'b0; resp_en = 1'b1; drive_mem();
    chk("s3_br_addr", mem.imem_addr, 32'h100); chk("s3_br_valid", 32'(ValidD), 32'd0);
    chk("s3_br_req", 32'(mem.imem_req), 32'd0);
    step(); chk("s3_d1_valid", 32'(ValidD), 32'd0); chk("s3_d1_req", 32'(mem.imem_req), 32'd1);
            chk("s3_d1_addr", mem.imem_addr, 32'h100);
    step(); chk("s3_d2_valid", 32'(ValidD), 32'd0);
    step(); chk("s3_d3_valid", 32'(ValidD), 32'd0);
    step(); chk("s3_t_valid", 32'(ValidD), 32'd1); chk("s3_t_pc8", PCPlus8D, 32'h108);
            chk("s3_t_instr", InstrD, instr_of(32'h100));

    // Grant withheld four cycles
    gnt_en = 1'b0; drive_mem();
    step(); chk("s4_w0_pc8", PCPlus8D, 32'h10C);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s4_w_valid", 32'(ValidD), 32'd0);
      chk("s4_w_addr", mem.imem_addr, 32'h108);
      chk("s4_w_req", 32'(mem.imem_req), 32'd1);
    end
    gnt_en = 1'b1; drive_mem();
    step(); step();
    step(); chk("s4_g_pc8", PCPlus8D, 32'h110); chk("s4_g_valid", 32'(ValidD), 32'd1);

    // Flush while stalled keeps the FIFO head
    gnt_en = 1'b0; drive_mem();
    StallD = 1'b1; FlushD = 1'b1;
    step(); chk("s5_f_valid", 32'(ValidD), 32'd0); chk("s5_f_instr", InstrD, 32'h0);
    FlushD = 1'b0;
    step(); chk("s5_s_valid", 32'(ValidD), 32'd0);
    StallD = 1'b0;
    step(); chk("s5_r_valid", 32'(ValidD), 32'd1); chk("s5_r_pc8", PCPlus8D, 32'h114);
            chk("s5_r_instr", InstrD, instr_of(32'h10C));

    // Reset with one request outstanding; responses during/after reset are dropped
    gnt_en = 1'b1; resp_en = 1'b0; drive_mem();
    step(); chk("s6_o_valid", 32'(ValidD), 32'd0);
    reset = 1'b1; resp_en = 1'b1; drive_mem(); #1;
    chk("s6_r_req", 32'(mem.imem_req), 32'd0);
    step(); chk("s6_r_valid", 32'(ValidD), 32'd0); chk("s6_r_pc8", PCPlus8D, 32'd8);
            chk("s6_r_addr", mem.imem_addr, 32'h0);
    reset = 1'b0; gnt_en = 1'b0; extra_rv = 1'b1; drive_mem(); #1;
    chk("s6_p_req", 32'(mem.imem_req), 32'd1); chk("s6_p_addr", mem.imem_addr, 32'h0);
    step();
    extra_rv = 1'b0; gnt_en = 1'b1; drive_mem();
    chk("s6_l_valid", 32'(ValidD), 32'd0); chk("s6_l_addr", mem.imem_addr, 32'h0);
    step(); step(); chk("s6_q_valid", 32'(ValidD), 32'd0);
    step(); chk("s6_f_valid", 32'(ValidD), 32'd1); chk("s6_f_pc8", PCPlus8D, 32'd8);
            chk("s6_f_instr", InstrD, instr_of(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
